// File: rtl/frogger_life_manager.sv
// frogger_life_manager
// Turns the registered collision flag into the death sequence: freeze the
// frog, blink the sprite, take a life, then either request a respawn or
// enter game-over. After each respawn a grace window ignores collisions.
module frogger_life_manager #(
  parameter int LIVES       = 3,   // 1..7
  parameter int DEATH_TICKS = 60,  // 1..255
  parameter int GRACE_TICKS = 30,  // 1..255
  parameter int BLINK_TICKS = 8    // 1..255
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Tick,
  input  logic       i_Collided,
  input  logic       i_Restart,
  output logic [2:0] o_Lives,
  output logic       o_Freeze,
  output logic       o_Respawn,
  output logic       o_Frog_Visible,
  output logic       o_Game_Over
);

  typedef enum logic [2:0] {
    ST_PLAY      = 3'd0,
    ST_DYING     = 3'd1,
    ST_RESPAWN   = 3'd2,
    ST_GRACE     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_TICKS - 1);
  localparam logic [7:0] GRACE_LAST = 8'(GRACE_TICKS - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] lives_nx;
  logic [7:0] tick_cnt;
  logic [7:0] tick_nx;
  logic [7:0] blink_cnt;
  logic [7:0] blink_nx;
  logic       blink_ph;
  logic       blink_ph_nx;
  logic       freeze_nx;
  logic       respawn_nx;
  logic       visible_nx;
  logic       game_over_nx;

  // Life count never wraps below zero.
  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // Next-state, counter and Moore output decode from the next state.
  always_comb begin
    state_nx     = state;
    lives_nx     = o_Lives;
    tick_nx      = tick_cnt;
    blink_nx     = blink_cnt;
    blink_ph_nx  = blink_ph;

    // Blink runs on every tick in DYING and GRACE; other states ignore it.
    if ((state == ST_DYING || state == ST_GRACE) && i_Tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_nx    = 8'd0;
        blink_ph_nx = ~blink_ph;
      end else begin
        blink_nx    = blink_cnt + 8'd1;
      end
    end

    case (state)
      ST_PLAY: begin
        // A tick in the same cycle as the collision is not counted.
        if (i_Collided) begin
          state_nx    = ST_DYING;
          lives_nx    = sat_dec(o_Lives);
          tick_nx     = 8'd0;
          blink_nx    = 8'd0;
          blink_ph_nx = 1'b0;
        end
      end
      ST_DYING: begin
        if (i_Tick) begin
          if (tick_cnt == DEATH_LAST) begin
            tick_nx  = 8'd0;
            state_nx = (o_Lives == 3'd0) ? ST_GAME_OVER : ST_RESPAWN;
          end else begin
            tick_nx  = tick_cnt + 8'd1;
          end
        end
      end
      ST_RESPAWN: begin
        // Single-cycle state; any tick here is dropped.
        state_nx    = ST_GRACE;
        tick_nx     = 8'd0;
        blink_nx    = 8'd0;
        blink_ph_nx = 1'b0;
      end
      ST_GRACE: begin
        if (i_Tick) begin
          if (tick_cnt == GRACE_LAST) begin
            tick_nx  = 8'd0;
            state_nx = ST_PLAY;
          end else begin
            tick_nx  = tick_cnt + 8'd1;
          end
        end
      end
      ST_GAME_OVER: begin
        if (i_Restart) begin
          lives_nx = LIVES_INIT;
          state_nx = ST_RESPAWN;
        end
      end
      default: begin
        state_nx = ST_PLAY;
      end
    endcase

    freeze_nx    = (state_nx == ST_DYING) || (state_nx == ST_RESPAWN) ||
                   (state_nx == ST_GAME_OVER);
    respawn_nx   = (state_nx == ST_RESPAWN);
    game_over_nx = (state_nx == ST_GAME_OVER);
    case (state_nx)
      ST_PLAY, ST_RESPAWN: visible_nx = 1'b1;
      ST_DYING, ST_GRACE:  visible_nx = blink_ph_nx;
      default:             visible_nx = 1'b0;
    endcase
  end

  // State, life count, counters and registered Moore outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state          <= ST_PLAY;
      o_Lives        <= LIVES_INIT;
      tick_cnt       <= 8'd0;
      blink_cnt      <= 8'd0;
      blink_ph       <= 1'b0;
      o_Freeze       <= 1'b0;
      o_Respawn      <= 1'b0;
      o_Game_Over    <= 1'b0;
      o_Frog_Visible <= 1'b1;
    end else begin
      state          <= state_nx;
      o_Lives        <= lives_nx;
      tick_cnt       <= tick_nx;
      blink_cnt      <= blink_nx;
      blink_ph       <= blink_ph_nx;
      o_Freeze       <= freeze_nx;
      o_Respawn      <= respawn_nx;
      o_Game_Over    <= game_over_nx;
      o_Frog_Visible <= visible_nx;
    end
  end

endmodule
